// File: rtl/riscv_pkg.sv
// Shared RV32I R-type definitions: r_func codes, request struct, encoder and legality check.
// r_func packs {instr[30], instr[25], funct3}; bit 3 (instr[25]) marks the unsupported M extension.
package riscv_pkg;

    typedef enum logic [4:0] {
        R_ADD  = 5'b00000,
        R_SLL  = 5'b00001,
        R_SLT  = 5'b00010,
        R_SLTU = 5'b00011,
        R_XOR  = 5'b00100,
        R_SRL  = 5'b00101,
        R_OR   = 5'b00110,
        R_AND  = 5'b00111,
        R_SUB  = 5'b10000,
        R_SRA  = 5'b10101
    } r_func;

    localparam logic [6:0]  OPC_R     = 7'b0110011;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        r_func      func;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } r_req_t;

    typedef enum logic {
        ST_ISSUE  = 1'b0,
        ST_BUBBLE = 1'b1
    } issue_state_t;

    function automatic logic [31:0] encode_r(input r_req_t r);
        logic [4:0] f;
        f = r.func;
        return {1'b0, f[4], 4'b0000, f[3], r.rs2, r.rs1, f[2:0], r.rd, OPC_R};
    endfunction

    function automatic logic r_legal(input logic [4:0] f);
        return !f[3] && (!f[4] || (f[2:0] == 3'b000) || (f[2:0] == 3'b101));
    endfunction

endpackage

// File: rtl/r_issue_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush; flush dominates push/pop.
// Latency: a pushed entry is visible at dout the cycle after the push. Backpressure: push ignored while full.
module r_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/r_instr_issuer.sv
// Encodes R-type requests into RV32I words, queues them and issues them in order with a running iaddr.
// Optional R_ISSUE_HAZARD_NOP_EN inserts an ADDI x0,x0,0 when the head reads the previous word's rd.
module r_instr_issuer
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4:0]             req_func,
    input  logic [4:0]             req_rd,
    input  logic [4:0]             req_rs1,
    input  logic [4:0]             req_rs2,
    output logic                   req_err,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            idata,
    output logic [31:0]            iaddr,
    output logic [$clog2(DEPTH):0] fifo_count
);

    issue_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_err_q, req_err_d;
    logic [31:0]  head, enc_word;
    logic         full, empty, accept, legal, push, pop, xfer, show_nop, hazard;
    r_req_t       req;

    always_comb begin
        req.func = r_func'(req_func);
        req.rd   = req_rd;
        req.rs1  = req_rs1;
        req.rs2  = req_rs2;
    end

    assign enc_word  = encode_r(req);
    assign legal     = r_legal(req_func);
    assign req_ready = !full;
    assign out_valid = !empty;
    assign accept    = req_valid && req_ready;
    assign push      = accept && legal && !flush;
    assign xfer      = out_valid && out_ready && !flush;
    assign pop       = xfer && !show_nop;
    assign req_err_d = accept && !legal && !flush;
    assign pc_d      = xfer ? pc_q + PC_STEP : pc_q;

    assign idata   = !out_valid ? 32'h0 : (show_nop ? INSTR_NOP : head);
    assign iaddr   = pc_q;
    assign req_err = req_err_q;

    r_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (enc_word),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

`ifdef R_ISSUE_HAZARD_NOP_EN
    logic [4:0] last_rd_q, last_rd_d;
    logic       last_vld_q, last_vld_d;

    assign hazard = last_vld_q && (last_rd_q != 5'd0) &&
                    ((head[19:15] == last_rd_q) || (head[24:20] == last_rd_q));

    always_comb begin
        last_rd_d  = last_rd_q;
        last_vld_d = last_vld_q;
        if (flush) begin
            last_vld_d = 1'b0;
        end else if (xfer) begin
            if (show_nop) begin
                last_vld_d = 1'b0;
            end else begin
                last_rd_d  = head[11:7];
                last_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_rd_q  <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_rd_q  <= last_rd_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign hazard = 1'b0;
`endif

    // BUBBLE holds the NOP stable while downstream stalls; the head stays queued underneath it.
    always_comb begin
        state_d  = state_q;
        show_nop = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                if (out_valid && hazard) begin
                    show_nop = 1'b1;
                    if (!out_ready) state_d = ST_BUBBLE;
                end
            end
            ST_BUBBLE: begin
                show_nop = 1'b1;
                if (out_ready) state_d = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
        endcase
        if (flush) state_d = ST_ISSUE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ISSUE;
            pc_q      <= PC_RESET;
            req_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_err_q <= req_err_d;
        end
    end

endmodule

// File: tb/tb_r_instr_issuer.sv
// Bench for r_instr_issuer: queue-based reference model checked every cycle, plus directed literal pins.
module tb_r_instr_issuer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] PCR   = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [4:0]  req_func, req_rd, req_rs1, req_rs2;
    logic        req_err, flush, out_valid, out_ready;
    logic [31:0] idata, iaddr;
    logic [2:0]  fifo_count;

    int tests = 0;
    int fails = 0;

    logic [31:0] mq[$];
    logic [31:0] m_pc;
    logic [4:0]  m_last_rd;
    bit          m_last_vld;
    bit          m_err;

    r_instr_issuer #(.DEPTH(DEPTH), .PC_RESET(PCR), .PC_STEP(32'd4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_func   (req_func),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_err    (req_err),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .idata      (idata),
        .iaddr      (iaddr),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] f, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        logic [31:0] w;
        w = 32'h33;
        w = w + ({27'b0, rd} << 7) + ({29'b0, f[2:0]} << 12);
        w = w + ({27'b0, rs1} << 15) + ({27'b0, rs2} << 20);
        w = w + ({31'b0, f[4]} << 30) + ({31'b0, f[3]} << 25);
        return w;
    endfunction

    function automatic bit legal(input logic [4:0] f);
        logic [2:0] f3;
        f3 = f[2:0];
        if (f[3]) return 1'b0;
        if (!f[4]) return 1'b1;
        return (f3 == 3'd0) || (f3 == 3'd5);
    endfunction

    function automatic bit m_nop();
        logic [31:0] h;
        logic [4:0]  s1, s2;
        if (mq.size() == 0) return 1'b0;
        h  = mq[0];
        s1 = h[19:15];
        s2 = h[24:20];
`ifdef R_ISSUE_HAZARD_NOP_EN
        return m_last_vld && (m_last_rd != 5'd0) && ((s1 == m_last_rd) || (s2 == m_last_rd));
`else
        return (s1 == 5'd0) && (s2 == 5'd0) && 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [31:0] w;
        chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        chk("req_ready", {31'b0, req_ready}, {31'b0, mq.size() < DEPTH});
        chk("fifo_count", {29'b0, fifo_count}, mq.size());
        chk("req_err", {31'b0, req_err}, {31'b0, m_err});
        chk("iaddr", iaddr, m_pc);
        if (mq.size() != 0) begin
            w = m_nop() ? 32'h0000_0013 : mq[0];
            chk("idata", idata, w);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc       = PCR;
        m_last_rd  = 5'd0;
        m_last_vld = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic model_update();
        bit          v, rdy, nop, acc;
        logic [31:0] w;
        v   = mq.size() != 0;
        rdy = mq.size() < DEPTH;
        nop = m_nop();
        acc = req_valid && rdy;
        m_err = acc && !legal(req_func) && !flush;
        if (flush) begin
            mq.delete();
            m_last_vld = 1'b0;
        end else begin
            if (v && out_ready) begin
                if (nop) begin
                    m_last_vld = 1'b0;
                end else begin
                    w          = mq.pop_front();
                    m_last_rd  = w[11:7];
                    m_last_vld = 1'b1;
                end
                m_pc = m_pc + 32'd4;
            end
            if (acc && legal(req_func)) mq.push_back(enc(req_func, req_rd, req_rs1, req_rs2));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic v, input logic [4:0] f, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        req_valid = v;
        req_func  = f;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        model_reset();
        compare();
        chk("rst_idata", idata, 32'h0);
        chk("rst_iaddr", iaddr, 32'hFFFF_FFFC);
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [4:0] legal_funcs [10] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                    5'b00101, 5'b00110, 5'b00111, 5'b10000, 5'b10101};

    initial begin
        logic [31:0] held;
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        flush     = 1'b0;
        out_ready = 1'b0;
        do_reset();

        // ADD x3,x1,x2 then SUB x4,x3,x1 (reads x3: hazard when the NOP feature is built in)
        out_ready = 1'b1;
        drive(1'b1, 5'b00000, 5'd3, 5'd1, 5'd2);
        step();
        chk("add_idata", idata, 32'h0020_81B3);
        chk("add_iaddr", iaddr, 32'hFFFF_FFFC);
        drive(1'b1, 5'b10000, 5'd4, 5'd3, 5'd1);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
`ifdef R_ISSUE_HAZARD_NOP_EN
        chk("nop_idata", idata, 32'h0000_0013);
        chk("nop_iaddr", iaddr, 32'h0000_0000);
        step();
        chk("sub_idata", idata, 32'h4011_8233);
        chk("sub_iaddr", iaddr, 32'h0000_0004);
`else
        chk("sub_idata", idata, 32'h4011_8233);
        chk("sub_iaddr", iaddr, 32'h0000_0000);
`endif
        step();

        // SUB x5,x6,x7 then SRA x10,x11,x12 back to back
        drive(1'b1, 5'b10000, 5'd5, 5'd6, 5'd7);
        step();
        drive(1'b1, 5'b10101, 5'd10, 5'd11, 5'd12);
        chk("sub2_idata", idata, 32'h4073_02B3);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("sra_idata", idata, 32'h40C5_D533);
        step();

        // Illegal M-extension code is dropped with a one-cycle error pulse
        drive(1'b1, 5'b10001, 5'd1, 5'd2, 5'd3);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("ill_err", {31'b0, req_err}, 32'd1);
        chk("ill_count", {29'b0, fifo_count}, 32'd0);
        step();
        chk("ill_err_end", {31'b0, req_err}, 32'd0);

        // Fill to DEPTH with out_ready low, fifth request waits for one pop
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'b00000, 5'(i), 5'd0, 5'd0);
            step();
            if (i == 4) chk("full_ready", {31'b0, req_ready}, 32'd0);
        end
        chk("full_count", {29'b0, fifo_count}, 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_ready", {31'b0, req_ready}, 32'd1);
        chk("pop_count", {29'b0, fifo_count}, 32'd3);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("fifth_count", {29'b0, fifo_count}, 32'd4);

        // Flush with pop requested: queue empties, iaddr holds
        held      = iaddr;
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_count", {29'b0, fifo_count}, 32'd0);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_iaddr", iaddr, held);

        // Randomized traffic with varying pressure on both sides
        for (int c = 0; c < 3000; c++) begin
            int phase;
            phase = c / 500;
            if (c == 1500) do_reset();
            if ($urandom_range(0, 7) == 0)
                drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            else
                drive($urandom_range(0, 3) < (phase % 3) + 1, legal_funcs[$urandom_range(0, 9)],
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            out_ready = ($urandom_range(0, 3) < ((phase + 1) % 4) + 1);
            flush     = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/r_instr_issuer.md
Name: r_instr_issuer

Overview:
- Initiator-side counterpart of the R-type execution unit: accepts abstract R-type operation requests (r_func, rd, rs1, rs2) over a valid/ready handshake.
- Encodes each request into a 32-bit RV32I R-type instruction word and buffers it in a small FIFO.
- Issues words in order, with a running instruction address, to the downstream instruction port (`idata`/`iaddr`).
- Used as a self-checking stimulus source and as the front end of the single-cycle bring-up path.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PC_RESET, 32'h0000_0000, `iaddr` value after reset.
- PC_STEP, 4, `iaddr` increment per issued word.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_func  in  5  r_func code {instr[30], instr[25], funct3}.
- req_rd  in  5  destination register.
- req_rs1  in  5  source register 1.
- req_rs2  in  5  source register 2.
- req_err  out  1  one-cycle pulse: illegal request dropped.
- flush  in  1  synchronous FIFO clear.
- out_valid  out  1  `idata`/`iaddr` valid.
- out_ready  in  1  downstream accepts word.
- idata  out  32  encoded instruction.
- iaddr  out  32  address of `idata`.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, low):
  - FIFO empty, `fifo_count`=0.
  - `out_valid`=0, `req_ready`=1, `req_err`=0.
  - `idata`=0, `iaddr`=PC_RESET.
  - Any in-flight request is lost.
- Encoding: opcode[6:0]=7'b0110011; rd[11:7]; funct3[14:12]=req_func[2:0]; rs1[19:15]; rs2[24:20]; bit30=req_func[4]; bit25=req_func[3]; all other funct7 bits 0.
- Legality: a request is legal iff req_func[3]=0 and (req_func[4]=0, or req_func[2:0] ∈ {000, 101}).
  - Illegal + handshake → not queued; `req_err`=1 next cycle for exactly one cycle.
- Request handshake:
  - Accept when `req_valid`&&`req_ready`.
  - `req_ready` = !full; it is a registered-state function and does not depend on `req_valid`.
  - No same-cycle pass-through: an accepted word is visible at the output no earlier than the next cycle (latency 1 when empty).
- Output handshake:
  - Head entry is driven on `idata`; `out_valid` = !empty.
  - Transfer when `out_valid`&&`out_ready`. `iaddr` += PC_STEP on each transfer, wrapping modulo 2^32.
  - While `out_valid`&&!`out_ready`, `idata`/`iaddr` hold stable.
- Simultaneous push+pop: allowed in any non-full state; count unchanged. When full, only pop occurs that cycle; `req_ready` rises the next cycle.
- flush=1:
  - Empties the FIFO next edge; `iaddr` unchanged.
  - Overrides a simultaneous push (request dropped silently, no `req_err`) and a pop (no `iaddr` increment).
- FSM, two states:
  - ISSUE: normal operation.
  - BUBBLE: used only with the optional feature; unreachable without it.
  - Reset and flush go to ISSUE.

Optional Feature:
- Macro: R_ISSUE_HAZARD_NOP_EN.
- When defined:
  - Track `last_rd` and `last_vld` of the most recently issued R-type word.
  - If head rs1 or rs2 == `last_rd`, with `last_rd`≠0 and `last_vld`, the FSM enters BUBBLE. It drives `idata`=32'h0000_0013 (ADDI x0,x0,0) with `out_valid`=1 in place of the head.
  - The NOP consumes one `iaddr` slot on transfer, clears `last_vld`, and returns to ISSUE; the head then issues normally.
  - Flush clears `last_vld`.
- When undefined: no tracking, no NOPs, and the BUBBLE logic is absent.

Decomposition:
- riscv_pkg holds:
  - the existing r_func enum;
  - new constants OPC_R=7'b0110011 and INSTR_NOP=32'h0000_0013;
  - an r_req_t struct {r_func func; logic [4:0] rd, rs1, rs2};
  - a function encode_r(r_req_t) returning the 32-bit word, reused by benches.
- One sub-module: r_issue_fifo, a parameterised synchronous FIFO with count, flush, and async active-low reset.

Test Plan:
- ADD x3,x1,x2 (func 5'b00000), out_ready=1, after reset → `idata`=32'h002081B3, `iaddr`=0, one cycle after acceptance.
- SUB x5,x6,x7 then SRA x10,x11,x12 → 32'h407302B3 at `iaddr` 0, then 32'h40C5D533 at `iaddr` 4.
- req_func=5'b10001 → not queued, `req_err` pulses one cycle, `fifo_count` stays 0.
- DEPTH=4, out_ready=0, 5 back-to-back requests → `req_ready`=0 after the 4th, `fifo_count`=4. Raise out_ready one cycle → the 5th is accepted the following cycle.
- PC_RESET=32'hFFFF_FFFC, two issues → `iaddr` FFFF_FFFC then 0000_0000. flush with 3 queued → `fifo_count`=0, `iaddr` held, `out_valid`=0.
- With R_ISSUE_HAZARD_NOP_EN: ADD x3,x1,x2 then SUB x4,x3,x1 → 32'h002081B3 @0, 32'h00000013 @4, 32'h40118233 @8. Without the macro → 32'h40118233 @4.
